// File: rtl/axis_packetizer_if.sv
// axis_packetizer_if
//   AXI4-Stream bundle used on both sides of axis_packetizer.
//   Signals: valid, data[DATA_WIDTH-1:0], last, ready.
//   Modports:
//     master - drives valid/data/last, samples ready (downstream-facing side)
//     slave  - samples valid/data, drives ready (upstream-facing side; the
//              upstream stream is unframed, so last is not part of it)
interface axis_packetizer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_packetizer.sv
// axis_packetizer
//   Groups an unframed AXI4-Stream into packets of cfg_pkt_len beats and
//   marks the final beat of each packet with m_axis.last. A two-entry
//   buffer (main output register + skid entry) gives full throughput with a
//   registered s_axis.ready.
// Ports:
//   axi_clk       - clock, rising edge
//   axi_reset_n   - asynchronous active-low reset
//   cfg_pkt_len   - beats per packet, sampled at packet start (0 acts as 1)
//   s_axis        - upstream stream (slave modport: valid, data, ready)
//   m_axis        - downstream stream (master modport: valid, data, last, ready)
//   stat_pkt_cnt  - packets delivered downstream (PACKETIZER_STATS_EN only)
//   stat_beat_cnt - beats delivered downstream (PACKETIZER_STATS_EN only)
// Build option:
//   PACKETIZER_STATS_EN - when defined, adds the two 32-bit wrapping
//   statistics counters and their output ports.
module axis_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
  axis_packetizer_if.slave     s_axis,
  axis_packetizer_if.master    m_axis
`ifdef PACKETIZER_STATS_EN
  ,
  output logic [31:0]          stat_pkt_cnt,
  output logic [31:0]          stat_beat_cnt
`endif
);

  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_last_q, main_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic                  s_ready_q, s_ready_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  logic                  s_hs_s;
  logic                  m_hs_s;
  logic [LEN_WIDTH-1:0]  eff_cfg_s;
  logic [LEN_WIDTH-1:0]  cur_len_s;
  logic                  beat_last_s;

  // Handshakes and per-beat framing decision.
  always_comb begin
    s_hs_s    = s_axis.valid & s_ready_q;
    m_hs_s    = m_valid_q & m_axis.ready;
    eff_cfg_s = (cfg_pkt_len == LEN_ZERO) ? LEN_ONE : cfg_pkt_len;
    // A fresh length is only taken when a packet starts; otherwise the
    // latched value governs the rest of the packet.
    cur_len_s   = (cnt_q == LEN_ZERO) ? eff_cfg_s : len_q;
    beat_last_s = (cnt_q == (cur_len_s - LEN_ONE));
  end

  // Next-state logic for the beat counter and the main/skid buffer.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    cnt_d       = cnt_q;
    len_d       = len_q;

    if (s_hs_s) begin
      len_d = cur_len_s;
      cnt_d = beat_last_s ? LEN_ZERO : (cnt_q + LEN_ONE);
    end else begin
      len_d = len_q;
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (s_hs_s) begin
          main_data_d = s_axis.data;
          main_last_d = beat_last_s;
          m_valid_d   = 1'b1;
          state_d     = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (s_hs_s && m_hs_s) begin
          main_data_d = s_axis.data;
          main_last_d = beat_last_s;
          state_d     = ST_ONE;
        end else if (s_hs_s) begin
          // Downstream stalled: park the new beat in the skid entry.
          skid_data_d = s_axis.data;
          skid_last_d = beat_last_s;
          state_d     = ST_TWO;
        end else if (m_hs_s) begin
          m_valid_d = 1'b0;
          state_d   = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        // s_axis.ready is low here, so no upstream beat can arrive.
        if (m_hs_s) begin
          main_data_d = skid_data_q;
          main_last_d = skid_last_q;
          state_d     = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ST_EMPTY;
      end
    endcase

    // Ready is registered and reflects whether the skid entry will be free.
    s_ready_d = (state_d != ST_TWO);
  end

  // Buffer, framing and ready registers.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q     <= ST_EMPTY;
      m_valid_q   <= 1'b0;
      main_data_q <= DATA_ZERO;
      main_last_q <= 1'b0;
      skid_data_q <= DATA_ZERO;
      skid_last_q <= 1'b0;
      s_ready_q   <= 1'b0;
      cnt_q       <= LEN_ZERO;
      len_q       <= LEN_ONE;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      s_ready_q   <= s_ready_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  assign s_axis.ready = s_ready_q;
  assign m_axis.valid = m_valid_q;
  assign m_axis.data  = main_data_q;
  assign m_axis.last  = main_last_q;

`ifdef PACKETIZER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Delivered-beat and delivered-packet counters; both wrap naturally.
  always_comb begin
    if (m_hs_s) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    if (m_hs_s && main_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      pkt_cnt_q  <= 32'd0;
      beat_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer
//   Scoreboard bench for axis_packetizer. Accepted upstream beats are pushed
//   with their expected last bit (from an independent framing model) and
//   compared against the beats the DUT delivers downstream.
module tb_axis_packetizer;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg;

  axis_packetizer_if #(.DATA_WIDTH(DW)) s_if ();
  axis_packetizer_if #(.DATA_WIDTH(DW)) m_if ();

`ifdef PACKETIZER_STATS_EN
  logic [31:0] stat_pkt;
  logic [31:0] stat_beat;
`endif

  axis_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .axi_clk     (clk),
    .axi_reset_n (rst_n),
    .cfg_pkt_len (cfg),
    .s_axis      (s_if),
    .m_axis      (m_if)
`ifdef PACKETIZER_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt),
    .stat_beat_cnt (stat_beat)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] src_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          s_cyc_q[$];
  int          got_cyc_q[$];
  int          mcnt;
  int          mlen;

  task automatic drive_src();
    s_if.valid = (src_q.size() > 0);
    s_if.data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
  endtask

  task automatic clear_sb();
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    s_cyc_q.delete();
    got_cyc_q.delete();
    mcnt = 0;
    mlen = 1;
  endtask

  // One clock: sample handshakes on the falling edge, update drive after rise.
  task automatic tick();
    logic s_hs;
    logic m_hs;
    logic lst;
    @(negedge clk);
    s_hs = s_if.valid & s_if.ready;
    m_hs = m_if.valid & m_if.ready;
    if (m_hs) begin
      got_q.push_back({m_if.last, m_if.data});
      got_cyc_q.push_back(cyc);
    end
    if (s_hs) begin
      if (mcnt == 0) mlen = (cfg == 16'd0) ? 1 : int'(cfg);
      lst = (mcnt == mlen - 1);
      exp_q.push_back({lst, src_q[0]});
      s_cyc_q.push_back(cyc);
      mcnt = lst ? 0 : mcnt + 1;
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_src();
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((src_q.size() > 0 || m_if.valid) && n < 200) begin
      tick();
      n++;
    end
    ok = (src_q.size() == 0) && !m_if.valid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sb();
    drive_src();
    m_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    cfg = 16'd4;
    m_if.ready = 1'b1;
    clear_sb();
    drive_src();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", m_if.valid); end
    checks++;
    if (m_if.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", m_if.last); end
    checks++;
    if (m_if.data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", m_if.data); end
    checks++;
    if (s_if.ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b required 0", s_if.ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_if.ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b required 0", s_if.ready); end
    @(posedge clk);
    #1;
    checks++;
    if (s_if.ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", s_if.ready); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [32:0] e, g;
    logic [32:0] arr[$];
    int nlast = 0;
    do_reset();
    cfg = 16'd4;
    for (int i = 1; i <= 12; i++) src_q.push_back(32'(i));
    drive_src();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: drained %0d required 1", ok); end
    arr = got_q;
    checks++;
    if (arr.size() != 12) begin errors++; $display("FAIL basic_count: got %0d required 12", arr.size()); end
    else begin
      for (int i = 0; i < 12; i++) if (arr[i][32]) nlast++;
      checks++;
      if (arr[3] !== {1'b1, 32'h4} || arr[7] !== {1'b1, 32'h8} || arr[11] !== {1'b1, 32'hC} || nlast != 3) begin
        errors++; $display("FAIL basic_last_pos: got %h %h %h lasts=%0d required 1_4 1_8 1_c lasts=3", arr[3], arr[7], arr[11], nlast);
      end
      checks++;
      if (got_cyc_q[0] != s_cyc_q[0] + 1) begin errors++; $display("FAIL basic_latency: got %0d required %0d", got_cyc_q[0] - s_cyc_q[0], 1); end
      checks++;
      if (got_cyc_q[11] - got_cyc_q[0] != 11) begin errors++; $display("FAIL basic_throughput: got %0d cycles required 11", got_cyc_q[11] - got_cyc_q[0]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL basic_beat: got nothing required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL basic_beat: got %h required %h", g, e); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [32:0] e, g;
    cfg = 16'd3;
    for (int i = 0; i < 9; i++) src_q.push_back(32'h21 + 32'(i));
    drive_src();
    repeat (3) tick();
    m_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (s_if.ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready: got %b required 0", s_if.ready); end
      checks++;
      if ({m_if.valid, m_if.last, m_if.data} !== {1'b1, 1'b1, 32'h23}) begin
        errors++; $display("FAIL stall_hold: got v=%b l=%b d=%h required v=1 l=1 d=00000023", m_if.valid, m_if.last, m_if.data);
      end
    end
    m_if.ready = 1'b1;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: drained %0d required 1", ok); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL stall_beat: got nothing required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL stall_beat: got %h required %h", g, e); end
      end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL stall_extra: got %0d extra beats required 0", got_q.size()); end
  endtask

  task automatic test_len_one();
    bit ok;
    logic [32:0] g;
    for (int p = 0; p < 2; p++) begin
      cfg = (p == 0) ? 16'd0 : 16'd1;
      for (int i = 0; i < 3; i++) src_q.push_back(32'h30 + 32'(p * 8 + i));
      drive_src();
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL len1_timeout: drained %0d required 1", ok); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL len1_beat: got nothing required %h", {1'b1, 32'h30 + 32'(p * 8 + i)}); end
        else begin
          g = got_q.pop_front();
          if (g !== {1'b1, 32'h30 + 32'(p * 8 + i)}) begin errors++; $display("FAIL len1_beat: got %h required %h", g, {1'b1, 32'h30 + 32'(p * 8 + i)}); end
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_cfg_change();
    bit ok;
    logic [32:0] e, g;
    logic [7:0] pat;
    logic [32:0] arr[$];
    pat = 8'b1010_1000;
    cfg = 16'd4;
    for (int i = 0; i < 8; i++) src_q.push_back(32'h41 + 32'(i));
    drive_src();
    while (src_q.size() > 6) tick();
    cfg = 16'd2;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cfgchg_timeout: drained %0d required 1", ok); end
    arr = got_q;
    checks++;
    if (arr.size() != 8) begin errors++; $display("FAIL cfgchg_count: got %0d required 8", arr.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (arr[i][32] !== pat[i]) begin errors++; $display("FAIL cfgchg_last: beat %0d got %b required %b", i, arr[i][32], pat[i]); end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL cfgchg_beat: got nothing required %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL cfgchg_beat: got %h required %h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [32:0] g;
    logic [32:0] arr[$];
    cfg = 16'd4;
    src_q.push_back(32'h51);
    src_q.push_back(32'h52);
    drive_src();
    while (src_q.size() > 0 && cyc < 90000) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_if.valid, m_if.last, m_if.data, s_if.ready} !== 35'h0) begin
      errors++; $display("FAIL midrst_outputs: got v=%b l=%b d=%h r=%b required all 0", m_if.valid, m_if.last, m_if.data, s_if.ready);
    end
    clear_sb();
    drive_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) src_q.push_back(32'hAA + 32'(i));
    drive_src();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: drained %0d required 1", ok); end
    arr = got_q;
    checks++;
    if (arr.size() != 4) begin errors++; $display("FAIL midrst_count: got %0d required 4", arr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        g = {(i == 3), 32'hAA + 32'(i)};
        checks++;
        if (arr[i] !== g) begin errors++; $display("FAIL midrst_beat: got %h required %h", arr[i], g); end
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

`ifdef PACKETIZER_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    cfg = 16'd4;
    for (int i = 1; i <= 12; i++) src_q.push_back(32'(i));
    drive_src();
    drain(ok);
    checks++;
    if (stat_beat !== 32'd12 || stat_pkt !== 32'd3) begin
      errors++; $display("FAIL stats_count: got beats=%0d pkts=%0d required 12 3", stat_beat, stat_pkt);
    end
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_cnt_q;
    release dut.beat_cnt_q;
    for (int i = 0; i < 4; i++) src_q.push_back(32'h60 + 32'(i));
    drive_src();
    drain(ok);
    checks++;
    if (stat_pkt !== 32'd0 || stat_beat !== 32'd2) begin
      errors++; $display("FAIL stats_wrap: got pkts=%h beats=%h required 0 2", stat_pkt, stat_beat);
    end
    clear_sb();
  endtask
`endif

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = 32'h0;
    s_if.last  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_len_one();
    test_cfg_change();
    test_reset_mid();
`ifdef PACKETIZER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
